// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the FIFO slice: pointer and occupancy-counter widths.
package fifo_pkg;

   function automatic int ptr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   // Occupancy must represent 0..depth inclusive, hence depth+1 states.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Circular pointer for a FIFO of arbitrary (non power-of-two) depth.
module fifo_wrap_ptr
   import fifo_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                        CLK,
   input  logic                        RESETN,
   input  logic                        CLEAR,
   input  logic                        INC,
   output logic [ptr_width(DEPTH)-1:0] PTR
);

   localparam int PW = ptr_width(DEPTH);

   // Wrap by explicit compare so depths that are not a power of two work.
   always_ff @(posedge CLK) begin
      if (!RESETN || CLEAR) begin
         PTR <= '0;
      end else if (INC) begin
         if (PTR == PW'(DEPTH - 1)) PTR <= '0;
         else                       PTR <= PTR + PW'(1);
      end
   end

endmodule

// File: rtl/fifo_level.sv
// First-word fall-through FIFO with occupancy count and level flags.
// Optional sticky OVERFLOW/UNDERFLOW outputs are enabled by FIFO_LEVEL_ERR_FLAGS_EN.
module fifo_level
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = 32,
   parameter int FIFO_DEPTH = 32,
   parameter int AF_LEVEL   = FIFO_DEPTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                                CLK,
   input  logic                                RESETN,
   input  logic                                CLEAR,
   input  logic                                WR_CMD,
   input  logic [FIFO_WIDTH-1:0]               WR_DATA,
   input  logic                                RD_CMD,
   output logic [FIFO_WIDTH-1:0]               RD_DATA,
   output logic                                FULL,
   output logic                                EMPTY,
   output logic                                ALMOST_FULL,
   output logic                                ALMOST_EMPTY,
`ifdef FIFO_LEVEL_ERR_FLAGS_EN
   output logic                                OVERFLOW,
   output logic                                UNDERFLOW,
`endif
   output logic [cnt_width(FIFO_DEPTH)-1:0]    COUNT
);

   localparam int PW = ptr_width(FIFO_DEPTH);
   localparam int CW = cnt_width(FIFO_DEPTH);

   if (FIFO_DEPTH < 2 || AF_LEVEL > FIFO_DEPTH || AE_LEVEL >= FIFO_DEPTH) begin : g_param_error
      $error("fifo_level: illegal FIFO_DEPTH/AF_LEVEL/AE_LEVEL combination");
   end

   logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count_q;
   logic                  wr_en;
   logic                  rd_en;

   // A simultaneous read frees a slot, so a full FIFO still accepts the write.
   assign wr_en = WR_CMD && (!FULL || RD_CMD);
   assign rd_en = RD_CMD && !EMPTY;

   fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
      .CLK    (CLK),
      .RESETN (RESETN),
      .CLEAR  (CLEAR),
      .INC    (wr_en),
      .PTR    (wr_ptr)
   );

   fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
      .CLK    (CLK),
      .RESETN (RESETN),
      .CLEAR  (CLEAR),
      .INC    (rd_en),
      .PTR    (rd_ptr)
   );

   // Storage is zeroed only by reset; a flush keeps the old words in place.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (wr_en && !CLEAR) begin
         mem[wr_ptr] <= WR_DATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETN || CLEAR) begin
         count_q <= '0;
      end else begin
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign RD_DATA      = mem[rd_ptr];
   assign COUNT        = count_q;
   assign FULL         = (count_q == CW'(FIFO_DEPTH));
   assign EMPTY        = (count_q == '0);
   assign ALMOST_FULL  = (count_q >= CW'(AF_LEVEL));
   assign ALMOST_EMPTY = (count_q <= CW'(AE_LEVEL));

`ifdef FIFO_LEVEL_ERR_FLAGS_EN
   always_ff @(posedge CLK) begin
      if (!RESETN || CLEAR) begin
         OVERFLOW  <= 1'b0;
         UNDERFLOW <= 1'b0;
      end else begin
         if (WR_CMD && FULL && !RD_CMD) OVERFLOW  <= 1'b1;
         if (RD_CMD && EMPTY)           UNDERFLOW <= 1'b1;
      end
   end
`endif

endmodule

// File: doc/fifo_level.md
FIFO_LEVEL -- requirements
Module: fifo_level

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 32, data word width in bits (>=1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 32, number of entries (>=2, need not be a power of two).
REQ-003 SHALL have parameter AF_LEVEL, default FIFO_DEPTH-2, occupancy at or above which ALMOST_FULL asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 2, occupancy at or below which ALMOST_EMPTY asserts.
REQ-005 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port RESETN  input  1  synchronous, active-low reset.
REQ-007 SHALL have port CLEAR  input  1  synchronous flush; entries discarded, storage contents retained.
REQ-008 SHALL have port WR_CMD  input  1  write request.
REQ-009 SHALL have port WR_DATA  input  FIFO_WIDTH  write data.
REQ-010 SHALL have port RD_CMD  input  1  read request; pops the word currently on RD_DATA.
REQ-011 SHALL have port RD_DATA  output  FIFO_WIDTH  head entry, combinational from storage (first-word fall-through).
REQ-012 SHALL have port FULL  output  1  occupancy == FIFO_DEPTH.
REQ-013 SHALL have port EMPTY  output  1  occupancy == 0.
REQ-014 SHALL have port ALMOST_FULL  output  1  occupancy >= AF_LEVEL.
REQ-015 SHALL have port ALMOST_EMPTY  output  1  occupancy <= AE_LEVEL.
REQ-016 SHALL have port COUNT  output  $clog2(FIFO_DEPTH+1)  current occupancy.

Function
REQ-017 SHALL accept a write when WR_CMD=1 and (FULL=0 or RD_CMD=1); word stored at back pointer.
REQ-018 SHALL accept a read when RD_CMD=1 and EMPTY=0; front pointer advances.
REQ-019 SHALL ignore a write when FULL=1 and RD_CMD=0 (no state change); ignore a read when EMPTY=1.
REQ-020 SHALL, on WR_CMD=RD_CMD=1 with EMPTY=1, perform the write only (no bypass to RD_DATA); COUNT 0->1.
REQ-021 SHALL, on WR_CMD=RD_CMD=1 with FULL=1, perform both; COUNT stays FIFO_DEPTH, FULL stays 1.
REQ-022 SHALL wrap each pointer from FIFO_DEPTH-1 to 0 by explicit compare, valid for non-power-of-two depth.
REQ-023 SHALL update COUNT as +1 (write only), -1 (read only), unchanged (both or neither), registered, visible the cycle after the accepting edge.
REQ-024 SHALL derive all flags from the registered count, so every flag changes in the same cycle as COUNT.
REQ-025 SHALL, when CLEAR=1, zero both pointers and COUNT next cycle regardless of WR_CMD/RD_CMD; CLEAR has priority over both.
REQ-026 SHALL present a new written word on RD_DATA one cycle after the write when the FIFO was empty.

Reset
REQ-027 SHALL on RESETN=0 at a rising edge set pointers=0, COUNT=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=(AF_LEVEL==0).
REQ-028 SHALL clear storage to 0 on reset so RD_DATA reads 0 after reset; reset mid-operation discards all entries and overrides CLEAR and commands.

Configuration
REQ-029 SHALL, with macro FIFO_LEVEL_ERR_FLAGS_EN defined, add outputs OVERFLOW and UNDERFLOW (1 bit each), sticky-set on an ignored write (REQ-019) or ignored read respectively, cleared only by reset or CLEAR.
REQ-030 SHALL, without FIFO_LEVEL_ERR_FLAGS_EN, omit those ports and logic entirely; all other behaviour identical.

Structure
REQ-031 SHALL place in shared package fifo_pkg: function ptr_width(depth) and function cnt_width(depth), used for pointer and COUNT widths.
REQ-032 SHALL instantiate sub-module fifo_wrap_ptr (parameter DEPTH; inputs CLK, RESETN, CLEAR, INC; output PTR) twice, once per pointer.
REQ-033 SHALL raise an elaboration error if FIFO_DEPTH<2, AF_LEVEL>FIFO_DEPTH, or AE_LEVEL>=FIFO_DEPTH.

Verification (FIFO_WIDTH=8, FIFO_DEPTH=5, AF_LEVEL=4, AE_LEVEL=1)
REQ-034 SHALL cover: write 0x11..0x55 on 5 consecutive cycles -> COUNT 1..5, ALMOST_FULL at COUNT=4, FULL at 5; 6th write 0x66 ignored, RD_DATA=0x11.
REQ-035 SHALL cover: from full, 7 simultaneous read+write cycles -> COUNT stays 5, pointers wrap past index 4, read order 0x11..0x55 then first two new words.
REQ-036 SHALL cover: from empty, RD_CMD=WR_CMD=1 with 0xA5 -> COUNT=1, EMPTY=0, RD_DATA=0xA5 next cycle; ALMOST_EMPTY stays 1.
REQ-037 SHALL cover: COUNT=3, CLEAR=1 with WR_CMD=1 -> next cycle COUNT=0, EMPTY=1, write discarded.
REQ-038 SHALL cover: RESETN=0 asserted while COUNT=4 -> next cycle COUNT=0, EMPTY=1, FULL=0, RD_DATA=0x00.
REQ-039 SHALL cover (FIFO_LEVEL_ERR_FLAGS_EN): read while empty -> UNDERFLOW=1 next cycle and held; write when full without read -> OVERFLOW=1; CLEAR clears both.
